// File: rtl/recovery_ctrl_multisrc_pkg.sv
// Shared types and helpers for the recovery controller slice.
package recovery_ctrl_multisrc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    ROLLBACK = 2'd2,
    FINISH   = 2'd3
  } recovery_state_t;

  // Distance from the ROB head modulo 2^w; a smaller value is an older instruction.
  function automatic logic [31:0] rob_age(input logic [31:0] tag, input logic [31:0] head,
                                          input int unsigned w);
    logic [31:0] d;
    d = tag - head;
    return (w >= 32) ? d : (d & ((32'd1 << w) - 32'd1));
  endfunction

endpackage

// File: rtl/recovery_ctrl_multisrc_if.sv
// Request/status bundle between the ROB/BU/LSU side and the recovery controller.
interface recovery_ctrl_multisrc_if #(
  parameter int unsigned NSRC   = 2,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned NRES   = 6,
  parameter int unsigned NSTAGE = 4
);
  logic [NSRC-1:0]       req_valid;
  logic [NSRC*TAG_W-1:0] req_tag;
  logic [TAG_W-1:0]      rob_head_tag;
  logic                  rollback_done;
  logic [NRES-1:0]       resource_full;
  logic                  recovery_start;
  logic                  recovery_flush;
  logic                  recovery_rollback;
  logic                  recovery_procedure;
  logic                  recovery_stall;
  logic [TAG_W-1:0]      flush_tag;
  logic                  flush_tag_valid;
  logic [NSRC-1:0]       flush_src;
  logic [NSTAGE-1:0]     stage_stall;
  logic [NSTAGE-1:0]     stage_flush;
  logic                  timeout_err;
  logic [15:0]           preempt_cnt;

  modport master (
    output req_valid, req_tag, rob_head_tag, rollback_done, resource_full,
    input  recovery_start, recovery_flush, recovery_rollback, recovery_procedure,
           recovery_stall, flush_tag, flush_tag_valid, flush_src, stage_stall,
           stage_flush, timeout_err, preempt_cnt
  );

  modport slave (
    input  req_valid, req_tag, rob_head_tag, rollback_done, resource_full,
    output recovery_start, recovery_flush, recovery_rollback, recovery_procedure,
           recovery_stall, flush_tag, flush_tag_valid, flush_src, stage_stall,
           stage_flush, timeout_err, preempt_cnt
  );
endinterface

// File: rtl/recovery_ctrl_multisrc_oldest_sel.sv
// Combinational selector: oldest valid request by ROB age, ties to the lower index.
module rob_age_oldest_sel
  import recovery_ctrl_multisrc_pkg::*;
#(
  parameter int unsigned NSRC  = 2,
  parameter int unsigned TAG_W = 6
) (
  input  logic [NSRC-1:0]       req_valid,
  input  logic [NSRC*TAG_W-1:0] req_tag,
  input  logic [TAG_W-1:0]      head_tag,
  output logic                  sel_valid,
  output logic [NSRC-1:0]       sel_onehot,
  output logic [TAG_W-1:0]      sel_tag,
  output logic [TAG_W-1:0]      sel_age
);
  logic [TAG_W-1:0] cur_tag;
  logic [TAG_W-1:0] cur_age;

  always_comb begin
    sel_valid  = 1'b0;
    sel_onehot = '0;
    sel_tag    = '0;
    sel_age    = '1;
    cur_tag    = '0;
    cur_age    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      cur_tag = req_tag[i*TAG_W +: TAG_W];
      cur_age = TAG_W'(rob_age(32'(cur_tag), 32'(head_tag), TAG_W));
      // Strict compare keeps the lower index on equal age.
      if (req_valid[i] && (!sel_valid || (cur_age < sel_age))) begin
        sel_valid  = 1'b1;
        sel_onehot = '0;
        sel_onehot[i] = 1'b1;
        sel_tag    = cur_tag;
        sel_age    = cur_age;
      end
    end
  end
endmodule

// File: rtl/recovery_ctrl_multisrc.sv
// Recovery controller: age arbitration, FLUSH/ROLLBACK sequencing with preemption and watchdog,
// plus per-stage stall/flush generation.
module recovery_ctrl_multisrc
  import recovery_ctrl_multisrc_pkg::*;
#(
  parameter int unsigned NSRC         = 2,
  parameter int unsigned TAG_W        = 6,
  parameter int unsigned NRES         = 6,
  parameter int unsigned NSTAGE       = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 256,
  parameter logic [NSTAGE*NRES-1:0] STALL_MASK  = '1,
  parameter logic [NSTAGE-1:0]      FRONT_FLUSH = '1,
  parameter logic [NSTAGE-1:0]      RECOV_STALL = '1
) (
  input logic clk,
  input logic rst,
  recovery_ctrl_multisrc_if.slave bus
);
  localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WC_W = $clog2(TIMEOUT);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  recovery_state_t  state, state_nxt;
  logic [FC_W-1:0]  fcnt;
  logic [WC_W-1:0]  wcnt;
  logic [TAG_W-1:0] flush_tag_q;
  logic [NSRC-1:0]  flush_src_q;
  logic             timeout_err_q;
  logic [15:0]      preempt_cnt_q;

  logic             sel_valid;
  logic [NSRC-1:0]  sel_onehot;
  logic [TAG_W-1:0] sel_tag;
  logic [TAG_W-1:0] sel_age;
  logic [TAG_W-1:0] cur_age;
  logic             start, preempt;
  logic             in_flush, in_procedure, stall_any;
  logic [NSTAGE-1:0] stall_vec, flush_vec;

  rob_age_oldest_sel #(.NSRC(NSRC), .TAG_W(TAG_W)) u_sel (
    .req_valid  (bus.req_valid),
    .req_tag    (bus.req_tag),
    .head_tag   (bus.rob_head_tag),
    .sel_valid  (sel_valid),
    .sel_onehot (sel_onehot),
    .sel_tag    (sel_tag),
    .sel_age    (sel_age)
  );

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    preempt   = 1'b0;
    cur_age   = TAG_W'(rob_age(32'(flush_tag_q), 32'(bus.rob_head_tag), TAG_W));
    unique case (state)
      IDLE, FINISH: begin
        start     = sel_valid;
        state_nxt = IDLE;
      end
      FLUSH: begin
        preempt = sel_valid && (sel_age < cur_age);
        start   = preempt;
        if (fcnt == '0) state_nxt = ROLLBACK;
      end
      ROLLBACK: begin
        preempt = sel_valid && (sel_age < cur_age);
        start   = preempt;
        if (bus.rollback_done) state_nxt = FINISH;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset suppresses the combinational start so nothing pulses while rst is held.
    if (rst) begin
      start   = 1'b0;
      preempt = 1'b0;
    end
    if (start) state_nxt = FLUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fcnt          <= '0;
      wcnt          <= '0;
      flush_tag_q   <= '0;
      flush_src_q   <= '0;
      timeout_err_q <= 1'b0;
      preempt_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ROLLBACK && !bus.rollback_done && wcnt == WC_LAST) timeout_err_q <= 1'b1;
      if (start) begin
        fcnt        <= FC_LOAD;
        wcnt        <= '0;
        flush_tag_q <= sel_tag;
        flush_src_q <= sel_onehot;
        if (preempt && preempt_cnt_q != '1) preempt_cnt_q <= preempt_cnt_q + 16'd1;
      end else begin
        if (state == FLUSH && fcnt != '0) fcnt <= fcnt - FC_W'(1);
        if (state == ROLLBACK && wcnt != WC_LAST) wcnt <= wcnt + WC_W'(1);
      end
    end
  end

  always_comb begin
    in_flush     = (state == FLUSH);
    in_procedure = (state != IDLE);
    stall_any    = in_procedure | start;
    stall_vec    = '0;
    flush_vec    = '0;
    for (int unsigned i = 0; i < NSTAGE; i++) begin
      stall_vec[i] = (|(bus.resource_full & STALL_MASK[i*NRES +: NRES])) | (stall_any & RECOV_STALL[i]);
      flush_vec[i] = (start & FRONT_FLUSH[i]) | in_flush;
    end
  end

  assign bus.recovery_start     = start;
  assign bus.recovery_flush     = in_flush;
  assign bus.recovery_rollback  = (state == ROLLBACK);
  assign bus.recovery_procedure = in_procedure;
  assign bus.recovery_stall     = stall_any;
  assign bus.flush_tag          = flush_tag_q;
  assign bus.flush_tag_valid    = in_flush;
  assign bus.flush_src          = flush_src_q;
  assign bus.stage_stall        = stall_vec;
  assign bus.stage_flush        = flush_vec;
  assign bus.timeout_err        = timeout_err_q;
  assign bus.preempt_cnt        = preempt_cnt_q;
endmodule

// File: tb/tb_recovery_ctrl_multisrc.sv
// Bench for recovery_ctrl_multisrc: directed scenarios plus random traffic against a behavioural model.
module tb_recovery_ctrl_multisrc;
  localparam int unsigned NSRC = 2, TAG_W = 6, NRES = 2, NSTAGE = 2;
  localparam int unsigned FLUSH_CYCLES = 2, TIMEOUT = 8;
  localparam logic [3:0] STALL_MASK  = {2'b10, 2'b01};
  localparam logic [1:0] FRONT_FLUSH = 2'b01;
  localparam logic [1:0] RECOV_STALL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recovery_ctrl_multisrc_if #(.NSRC(NSRC), .TAG_W(TAG_W), .NRES(NRES), .NSTAGE(NSTAGE)) bus ();

  recovery_ctrl_multisrc #(
    .NSRC(NSRC), .TAG_W(TAG_W), .NRES(NRES), .NSTAGE(NSTAGE),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TIMEOUT(TIMEOUT),
    .STALL_MASK(STALL_MASK), .FRONT_FLUSH(FRONT_FLUSH), .RECOV_STALL(RECOV_STALL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 flush, 2 rollback, 3 finish.
  int unsigned m_ph, m_flush_left, m_rb, m_tag, m_src, m_pre;
  bit m_terr;
  bit e_start;
  int unsigned e_wtag, e_wsrc;
  logic [34:0] cmp_act, cmp_exp;

  function automatic int unsigned age(input int unsigned t);
    return (t + 64 - int'(bus.rob_head_tag)) % 64;
  endfunction

  function automatic void eval();
    int unsigned best, t;
    bit found;
    best = 0; found = 0; e_wtag = 0; e_wsrc = 0;
    for (int i = 0; i < NSRC; i++) begin
      t = int'((bus.req_tag >> (i * TAG_W)) & 12'd63);
      if (bus.req_valid[i] && (!found || age(t) < best)) begin
        found = 1; best = age(t); e_wtag = t; e_wsrc = 1 << i;
      end
    end
    e_start = !rst && found && (m_ph == 0 || m_ph == 3 || best < age(m_tag));
  endfunction

  function automatic logic [34:0] expect_vec();
    logic [1:0] ss, sf;
    bit fl, proc, stall;
    eval();
    fl = (m_ph == 1);
    proc = (m_ph != 0);
    stall = proc | e_start;
    for (int i = 0; i < NSTAGE; i++) begin
      ss[i] = (|(bus.resource_full & STALL_MASK[i*NRES +: NRES])) | (stall & RECOV_STALL[i]);
      sf[i] = (e_start & FRONT_FLUSH[i]) | fl;
    end
    return {e_start, fl, (m_ph == 2), proc, stall, 6'(m_tag), fl, 2'(m_src), ss, sf, m_terr, 16'(m_pre)};
  endfunction

  function automatic logic [34:0] act_vec();
    return {bus.recovery_start, bus.recovery_flush, bus.recovery_rollback, bus.recovery_procedure,
            bus.recovery_stall, bus.flush_tag, bus.flush_tag_valid, bus.flush_src, bus.stage_stall,
            bus.stage_flush, bus.timeout_err, bus.preempt_cnt};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_flush_left = 0; m_rb = 0; m_tag = 0; m_src = 0; m_pre = 0; m_terr = 0;
    end else begin
      eval();
      if (m_ph == 2 && m_rb >= TIMEOUT - 1 && !bus.rollback_done) m_terr = 1;
      if (e_start) begin
        if (m_ph == 1 || m_ph == 2) m_pre = (m_pre == 65535) ? m_pre : m_pre + 1;
        m_ph = 1; m_flush_left = FLUSH_CYCLES; m_rb = 0; m_tag = e_wtag; m_src = e_wsrc;
      end else begin
        case (m_ph)
          1: begin
            m_flush_left--;
            if (m_flush_left == 0) begin m_ph = 2; m_rb = 0; end
          end
          2: if (bus.rollback_done) m_ph = 3; else m_rb++;
          3: m_ph = 0;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_act = act_vec();
      cmp_exp = expect_vec();
      tests++;
      if (cmp_act !== cmp_exp) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t act=%h exp=%h", $time, cmp_act, cmp_exp);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.req_valid = '0; bus.req_tag = '0; bus.rollback_done = 1'b0; bus.resource_full = '0;
  endtask

  task automatic set_req(input logic [1:0] v, input int unsigned t0, input int unsigned t1);
    bus.req_valid = v;
    bus.req_tag = {6'(t1), 6'(t0)};
  endtask

  // Let any active recovery complete, acknowledging rollback as soon as it is reached.
  task automatic drain();
    int unsigned n;
    n = 0;
    bus.req_valid = '0;
    while (bus.recovery_procedure !== 1'b0 && n < 30) begin
      bus.rollback_done = bus.recovery_rollback;
      nxt();
      n++;
    end
    bus.rollback_done = 1'b0;
    tests++;
    if (n >= 30) begin
      fails++;
      $display("FAIL drain_timeout act=%0d exp<30", n);
    end
  endtask

  task automatic to_rollback();
    int unsigned n;
    n = 0;
    while (bus.recovery_rollback !== 1'b1 && n < 10) begin nxt(); n++; end
    tests++;
    if (n >= 10) begin
      fails++;
      $display("FAIL rollback_wait act=%0d exp<10", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle_in();
    bus.rob_head_tag = '0;
    rst = 1'b1;
    nxt(); nxt();
    chk_en = 1'b1;
    neg();
    check("rst_proc", bus.recovery_procedure, 0);
    check("rst_tag", bus.flush_tag, 0);
    check("rst_pcnt", bus.preempt_cnt, 0);
    check("rst_terr", bus.timeout_err, 0);
    nxt();
    rst = 1'b0;

    // Single request timeline
    set_req(2'b01, 5, 0);
    neg();
    check("t0_start", bus.recovery_start, 1);
    check("t0_sflush", bus.stage_flush, 2'b01);
    nxt(); bus.req_valid = '0;
    neg();
    check("t1_flush", bus.recovery_flush, 1);
    check("t1_tag", bus.flush_tag, 5);
    check("t1_src", bus.flush_src, 2'b01);
    check("t1_sflush", bus.stage_flush, 2'b11);
    nxt(); neg();
    check("t2_flush", bus.recovery_flush, 1);
    nxt(); neg();
    check("t3_rb", bus.recovery_rollback, 1);
    nxt();
    nxt(); bus.rollback_done = 1'b1;
    neg();
    check("t5_rb", bus.recovery_rollback, 1);
    nxt(); bus.rollback_done = 1'b0;
    neg();
    check("t6_finish", {bus.recovery_procedure, bus.recovery_rollback, bus.recovery_flush}, 3'b100);
    nxt(); neg();
    check("t7_idle", bus.recovery_procedure, 0);
    check("t7_tag", bus.flush_tag, 5);
    check("t7_src", bus.flush_src, 2'b01);
    check("model_tag", m_tag, 5);

    // Arbitration across the tag wrap, then equal tags
    nxt();
    bus.rob_head_tag = 6'd60;
    set_req(2'b11, 2, 62);
    neg();
    check("wrap_start", bus.recovery_start, 1);
    nxt(); bus.req_valid = '0;
    neg();
    check("wrap_tag", bus.flush_tag, 62);
    check("wrap_src", bus.flush_src, 2'b10);
    check("model_wrap_src", m_src, 2);
    drain();
    set_req(2'b11, 7, 7);
    nxt(); bus.req_valid = '0;
    neg();
    check("eq_src", bus.flush_src, 2'b01);
    check("eq_tag", bus.flush_tag, 7);
    drain();

    // Preemption beats a simultaneous rollback_done
    bus.rob_head_tag = '0;
    set_req(2'b01, 10, 0);
    nxt(); bus.req_valid = '0;
    to_rollback();
    set_req(2'b10, 0, 4);
    bus.rollback_done = 1'b1;
    neg();
    check("pre_start", bus.recovery_start, 1);
    nxt(); bus.req_valid = '0; bus.rollback_done = 1'b0;
    neg();
    check("pre_flush", bus.recovery_flush, 1);
    check("pre_tag", bus.flush_tag, 4);
    check("pre_cnt", bus.preempt_cnt, 1);
    check("model_pre", m_pre, 1);
    drain();
    set_req(2'b01, 10, 0);
    nxt(); bus.req_valid = '0;
    to_rollback();
    set_req(2'b10, 0, 12);
    bus.rollback_done = 1'b1;
    neg();
    check("young_start", bus.recovery_start, 0);
    nxt(); bus.req_valid = '0; bus.rollback_done = 1'b0;
    neg();
    check("young_finish", {bus.recovery_procedure, bus.recovery_rollback, bus.recovery_flush}, 3'b100);
    check("young_cnt", bus.preempt_cnt, 1);
    drain();

    // Stall masking
    bus.resource_full = 2'b01;
    neg();
    check("stall_idle", bus.stage_stall, 2'b01);
    set_req(2'b01, 9, 0);
    nxt(); bus.req_valid = '0;
    neg();
    check("stall_recov", bus.stage_stall, 2'b11);
    drain();
    bus.resource_full = '0;

    // Watchdog: error appears on the 9th rollback cycle and is sticky
    set_req(2'b01, 3, 0);
    nxt(); bus.req_valid = '0;
    nxt(); nxt();
    repeat (7) nxt();
    neg();
    check("wd_8th_rb", bus.recovery_rollback, 1);
    check("wd_8th_err", bus.timeout_err, 0);
    nxt(); neg();
    check("wd_9th_err", bus.timeout_err, 1);
    bus.rollback_done = 1'b1;
    nxt(); bus.rollback_done = 1'b0;
    drain();
    neg();
    check("wd_sticky", {bus.recovery_procedure, bus.timeout_err}, 2'b01);

    // Reset during FLUSH
    set_req(2'b01, 20, 0);
    nxt(); bus.req_valid = '0;
    rst = 1'b1;
    nxt(); rst = 1'b0;
    neg();
    check("rst_flush_all", act_vec(), 0);
    nxt();
    set_req(2'b01, 21, 0);
    neg();
    check("rst_restart", bus.recovery_start, 1);
    nxt(); bus.req_valid = '0;
    neg();
    check("rst_restart_tag", bus.flush_tag, 21);
    drain();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst = ($urandom_range(0, 199) == 0);
      bus.req_valid = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      bus.req_tag = 12'($urandom);
      if ($urandom_range(0, 9) == 0) bus.rob_head_tag = 6'($urandom);
      bus.rollback_done = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      bus.resource_full = 2'($urandom);
    end
    nxt();
    idle_in();
    rst = 1'b0;
    nxt(); nxt();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
